video_capture_scheduler: RTL and testbench
==========================================

VIDEO_CAPTURE_SCHEDULER -- requirements
Module: video_capture_scheduler

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 16: clk cycles to wait after any sel change before honouring frame_start.
REQ-002 SHALL have parameter NSRC, default 15: number of video sources, indexed 1..NSRC.
REQ-003 Port clk, input, 1: single clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port start, input, 1: one-cycle pulse that begins a scan.
REQ-006 Port stop, input, 1: one-cycle pulse that requests the scan to end.
REQ-007 Port enable_mask, input, 15: bit i-1 enables source i.
REQ-008 Port dwell_frames, input, 8: frames captured per source; 0 is treated as 1.
REQ-009 Port frame_start, input, 1: one-cycle start-of-frame pulse, already synchronised to clk.
REQ-010 Port sel, output, 6: source select for the video mux, valid values 1..NSRC.
REQ-011 Port capture_arm, output, 1: one-cycle pulse that arms the logic-analyser trigger.
REQ-012 Port switch_pulse, output, 1: one-cycle pulse on every sel change.
REQ-013 Port busy, output, 1: high in every state except IDLE.
REQ-014 Port frame_cnt, output, 8: frames completed on the current source.

Function
REQ-015 FSM states SHALL be IDLE, SEEK, SETTLE, WAIT_SOF and CAPTURE.
REQ-016 IDLE: start with enable_mask!=0 SHALL go to SEEK; start with mask==0 SHALL be ignored.
REQ-017 SEEK (exactly 1 cycle) SHALL load sel with the next enabled index above the current sel, wrapping NSRC->1, and pulse switch_pulse only if the value changes.
- If the only enabled source equals the current sel, sel SHALL be unchanged and there SHALL be no switch_pulse.
REQ-018 SEEK SHALL go to SETTLE and load the settle counter with SETTLE_CYC-1.
REQ-019 SETTLE SHALL decrement the counter, ignore frame_start, and go to WAIT_SOF on the cycle the counter reaches 0.
REQ-020 WAIT_SOF: on frame_start, the next cycle SHALL be CAPTURE, with capture_arm high for that one cycle and frame_cnt=0.
REQ-021 CAPTURE: each frame_start SHALL increment frame_cnt (saturating at 255).
- When the increment makes frame_cnt equal the effective dwell, the FSM SHALL go to SEEK.
- The frame_start that ends the dwell SHALL NOT arm a new capture.
REQ-022 enable_mask and dwell_frames SHALL be sampled only in SEEK; changes in other states take effect at the next SEEK.
REQ-023 stop SHALL set a sticky stop_req flag; in SEEK, stop_req set SHALL go to IDLE (clearing the flag) instead of changing sel.
REQ-024 stop in IDLE SHALL be ignored; start while busy SHALL be ignored.
REQ-025 If enable_mask==0 at SEEK, the FSM SHALL go to IDLE with sel unchanged.
REQ-026 start and stop in the same cycle in IDLE: the scan SHALL start and end at the first SEEK, i.e. one sel change and no capture.
REQ-027 sel SHALL be registered, glitch-free and change only in SEEK; sel SHALL never output 0 or a value above NSRC.
REQ-028 Latency from start to the first capture_arm SHALL be 1 (SEEK) + SETTLE_CYC + the wait for frame_start + 1 cycles.

Reset
REQ-029 On rst: state=IDLE, sel=6'd1, capture_arm=0, switch_pulse=0, busy=0, frame_cnt=0, stop_req=0, settle counter=0.
REQ-030 rst asserted mid-scan SHALL abort immediately to the reset values, with no pending pulses after release.

Structure
REQ-031 A shared package SHALL hold the state enum, the SEL_MIN=1 and SEL_MAX=15 constants, and the 6-bit sel width.
REQ-032 The next-enabled-index search SHALL be a sub-module src_next_finder (combinational: mask and current sel in, next index and found flag out).

Verification
REQ-033 mask=15'h0005, dwell=2, SETTLE_CYC=4, start -> sel 3, then 1, then 3…; one capture_arm per source visit; switch_pulse on each change.
REQ-034 mask=15'h4000, sel=1, start -> sel jumps to 15; a following SEEK keeps sel=15 with no switch_pulse.
REQ-035 frame_start pulses during SETTLE -> no capture_arm; the first frame_start after SETTLE arms the capture.
REQ-036 stop during CAPTURE with dwell=3 -> three frames complete, then IDLE, busy=0, sel holds its last value.
REQ-037 dwell=0 -> behaves as dwell=1: one frame per source.
REQ-038 rst pulse in CAPTURE -> sel=1, busy=0, no capture_arm or switch_pulse until the next start.

Source files
------------

// File: rtl/video_capture_scheduler_pkg.sv
// Shared types and constants for the video capture scheduler: FSM states,
// select-range limits and the dwell normalisation helper.
package video_capture_scheduler_pkg;

    localparam int SEL_W = 6;
    localparam logic [SEL_W-1:0] SEL_MIN = 6'd1;
    localparam logic [SEL_W-1:0] SEL_MAX = 6'd15;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEEK     = 3'd1,
        SETTLE   = 3'd2,
        WAIT_SOF = 3'd3,
        CAPTURE  = 3'd4
    } state_t;

    // A dwell of zero frames would never end a visit, so it means one frame.
    function automatic logic [7:0] eff_dwell(input logic [7:0] d);
        return (d == 8'd0) ? 8'd1 : d;
    endfunction

endpackage

// File: rtl/video_capture_scheduler_src_next_finder.sv
// Combinational search for the next enabled source strictly after the current
// select, wrapping NSRC -> 1; the current source itself is the last candidate.
module src_next_finder
    import video_capture_scheduler_pkg::*;
#(
    parameter int NSRC = 15
) (
    input  logic [NSRC-1:0]  i_mask,
    input  logic [SEL_W-1:0] i_cur_sel,
    output logic [SEL_W-1:0] o_next_sel,
    output logic             o_found
);

    localparam logic [SEL_W-1:0] NSRC_W = SEL_W'(NSRC);

    logic [2*NSRC-1:0] w_dbl;
    logic [2*NSRC-1:0] w_rot;
    logic [NSRC-1:0]   w_ahead;
    logic [SEL_W-1:0]  w_step;
    logic [SEL_W-1:0]  w_sum;

    always_comb begin
        // After rotating, bit j of w_ahead is source i_cur_sel+j+1 (wrapped).
        w_dbl   = {i_mask, i_mask};
        w_rot   = w_dbl >> i_cur_sel;
        w_ahead = w_rot[NSRC-1:0];
        w_step  = '0;
        o_found = 1'b0;
        for (int j = 0; j < NSRC; j++) begin
            if (!o_found && w_ahead[0]) begin
                o_found = 1'b1;
                w_step  = SEL_W'(j);
            end
            w_ahead = w_ahead >> 1;
        end
        w_sum = i_cur_sel + w_step + SEL_W'(1);
        if (w_sum > NSRC_W) begin
            w_sum = w_sum - NSRC_W;
        end
        o_next_sel = o_found ? w_sum : i_cur_sel;
    end

endmodule

// File: rtl/video_capture_scheduler.sv
// Round-robin video source scheduler: steps sel through enabled sources, waits
// for the mux to settle, then arms a capture and counts dwell frames per source.
module video_capture_scheduler
    import video_capture_scheduler_pkg::*;
#(
    parameter int SETTLE_CYC = 16,
    parameter int NSRC       = 15
) (
    input  logic            clk,
    input  logic            rst,
    // start, stop and frame_start are single-cycle strobes sampled on the
    // rising edge; there is no back-pressure and a strobe is never held off.
    input  logic            start,
    input  logic            stop,
    input  logic [NSRC-1:0] enable_mask,
    input  logic [7:0]      dwell_frames,
    input  logic            frame_start,
    output logic [5:0]      sel,
    output logic            capture_arm,
    output logic            switch_pulse,
    output logic            busy,
    output logic [7:0]      frame_cnt,
    output logic [2:0]      dbg_state
);

    localparam int CNT_W        = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
    localparam int SETTLE_LOADI = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_LOADI);

    state_t           r_state;
    logic [SEL_W-1:0] r_sel;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_frame_cnt;
    logic [7:0]       r_dwell;
    logic             r_stop_req;
    logic             r_first_seek;
    logic             r_capture_arm;
    logic             r_switch_pulse;

    state_t           w_state_nxt;
    logic [SEL_W-1:0] w_sel_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [7:0]       w_frame_nxt;
    logic [7:0]       w_dwell_nxt;
    logic             w_stop_nxt;
    logic             w_first_nxt;
    logic             w_arm_nxt;
    logic             w_sw_nxt;
    logic [7:0]       w_frame_inc;
    logic [SEL_W-1:0] w_next_sel;
    logic             w_found;

    src_next_finder #(
        .NSRC(NSRC)
    ) u_finder (
        .i_mask    (enable_mask),
        .i_cur_sel (r_sel),
        .o_next_sel(w_next_sel),
        .o_found   (w_found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_sel          <= SEL_MIN;
            r_cnt          <= '0;
            r_frame_cnt    <= 8'd0;
            r_dwell        <= 8'd1;
            r_stop_req     <= 1'b0;
            r_first_seek   <= 1'b0;
            r_capture_arm  <= 1'b0;
            r_switch_pulse <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_sel          <= w_sel_nxt;
            r_cnt          <= w_cnt_nxt;
            r_frame_cnt    <= w_frame_nxt;
            r_dwell        <= w_dwell_nxt;
            r_stop_req     <= w_stop_nxt;
            r_first_seek   <= w_first_nxt;
            r_capture_arm  <= w_arm_nxt;
            r_switch_pulse <= w_sw_nxt;
        end
    end

    assign w_frame_inc = (r_frame_cnt == 8'hFF) ? 8'hFF : r_frame_cnt + 8'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        w_frame_nxt = r_frame_cnt;
        w_dwell_nxt = r_dwell;
        w_stop_nxt  = r_stop_req;
        w_first_nxt = r_first_seek;
        w_arm_nxt   = 1'b0;
        w_sw_nxt    = 1'b0;

        if (stop && (r_state != IDLE)) begin
            w_stop_nxt = 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (start && (|enable_mask)) begin
                    w_state_nxt = SEEK;
                    w_first_nxt = 1'b1;
                    // A stop arriving with start lets the scan make its first
                    // select change and then end without capturing.
                    w_stop_nxt  = stop;
                end
            end
            SEEK: begin
                w_first_nxt = 1'b0;
                if ((r_stop_req && !r_first_seek) || !w_found) begin
                    w_state_nxt = IDLE;
                    w_stop_nxt  = 1'b0;
                end else begin
                    w_sel_nxt   = w_next_sel;
                    w_sw_nxt    = (w_next_sel != r_sel);
                    w_dwell_nxt = eff_dwell(dwell_frames);
                    if (r_stop_req) begin
                        w_state_nxt = IDLE;
                        w_stop_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = SETTLE;
                        w_cnt_nxt   = SETTLE_LOAD;
                    end
                end
            end
            SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = WAIT_SOF;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            WAIT_SOF: begin
                if (frame_start) begin
                    w_state_nxt = CAPTURE;
                    w_arm_nxt   = 1'b1;
                    w_frame_nxt = 8'd0;
                end
            end
            CAPTURE: begin
                if (frame_start) begin
                    w_frame_nxt = w_frame_inc;
                    if (w_frame_inc == r_dwell) begin
                        w_state_nxt = SEEK;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign sel          = r_sel;
    assign capture_arm  = r_capture_arm;
    assign switch_pulse = r_switch_pulse;
    assign busy         = (r_state != IDLE);
    assign frame_cnt    = r_frame_cnt;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_video_capture_scheduler.sv
// Randomised bench for video_capture_scheduler: a visit-level timing model
// predicts sel, pulses and frame counts from the scan rules.
module tb_video_capture_scheduler;
    import video_capture_scheduler_pkg::*;

    localparam int S    = 4;
    localparam int NSRC = 15;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic [14:0] enable_mask;
    logic [7:0]  dwell_frames;
    logic        frame_start;
    logic [5:0]  sel;
    logic        capture_arm;
    logic        switch_pulse;
    logic        busy;
    logic [7:0]  frame_cnt;
    logic [2:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int bad_range = 0;
    int bad_sw = 0;
    logic [5:0] prev_sel;
    logic [5:0] m_sel;

    video_capture_scheduler #(
        .SETTLE_CYC(S),
        .NSRC      (NSRC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .enable_mask (enable_mask),
        .dwell_frames(dwell_frames),
        .frame_start (frame_start),
        .sel         (sel),
        .capture_arm (capture_arm),
        .switch_pulse(switch_pulse),
        .busy        (busy),
        .frame_cnt   (frame_cnt),
        .dbg_state   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sel must stay in range and every visible change must carry a switch_pulse.
    always @(negedge clk) begin
        if (rst) begin
            prev_sel = sel;
        end else begin
            if (sel < 6'd1 || sel > 6'd15) bad_range++;
            if ((sel != prev_sel) != switch_pulse) bad_sw++;
            prev_sel = sel;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] next_en(input logic [14:0] mask, input logic [5:0] cur);
        logic [5:0] r;
        int c;
        r = cur;
        for (int k = NSRC; k >= 1; k--) begin
            c = ((int'(cur) - 1 + k) % NSRC) + 1;
            if (((mask >> (c - 1)) & 15'd1) != 15'd0) r = 6'(c);
        end
        return r;
    endfunction

    function automatic int eff(input logic [7:0] d);
        return (d == 8'd0) ? 1 : int'(d);
    endfunction

    function automatic logic [14:0] rand_mask();
        if ($urandom_range(0, 2) == 0) return 15'd1 << $urandom_range(0, 14);
        return 15'($urandom_range(1, 32767));
    endfunction

    // Caller leaves the DUT in SEEK; returns on the edge that ends the dwell.
    task automatic visit(input logic [5:0] exp_sel, input logic exp_sw, input int dwell,
                         input logic do_stop);
        int gap;
        tick();
        check("seek_sel", 32'(sel), 32'(exp_sel));
        check("seek_switch", 32'(switch_pulse), 32'(exp_sw));
        check("seek_busy", 32'(busy), 1);
        enable_mask  = 15'($urandom);
        dwell_frames = 8'($urandom_range(0, 255));
        for (int i = 0; i < S; i++) begin
            frame_start = 1'($urandom_range(0, 1));
            start       = ($urandom_range(0, 3) == 0);
            tick();
            check("settle_no_arm", 32'(capture_arm), 0);
        end
        frame_start = 1'b0;
        start       = 1'b0;
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
            tick();
            check("wait_no_arm", 32'(capture_arm), 0);
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("arm", 32'(capture_arm), 1);
        check("arm_frame_cnt", 32'(frame_cnt), 0);
        for (int k = 1; k <= dwell; k++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                stop = do_stop && (k == 1) && (g == 0);
                tick();
                stop = 1'b0;
                check("cap_hold_cnt", 32'(frame_cnt), 32'(k - 1));
                check("cap_no_arm", 32'(capture_arm), 0);
            end
            stop        = do_stop && (k == 1) && (gap == 0);
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            stop        = 1'b0;
            check("frame_cnt", 32'(frame_cnt), 32'(k));
            check("frame_no_arm", 32'(capture_arm), 0);
        end
    endtask

    task automatic expect_idle(input logic [5:0] exp_sel);
        tick();
        check("end_busy", 32'(busy), 0);
        check("end_sel", 32'(sel), 32'(exp_sel));
        check("end_switch", 32'(switch_pulse), 0);
        for (int i = 0; i < 3; i++) begin
            frame_start = 1'($urandom_range(0, 1));
            tick();
            check("idle_no_arm", 32'(capture_arm), 0);
            check("idle_busy", 32'(busy), 0);
        end
        frame_start = 1'b0;
    endtask

    task automatic run_scan(input int nvis, input logic fixed, input logic [14:0] fmask,
                            input logic [7:0] fdwell);
        logic [14:0] m;
        logic [7:0]  d;
        logic [5:0]  nx;
        m = fixed ? fmask : rand_mask();
        d = fixed ? fdwell : 8'($urandom_range(0, 3));
        enable_mask  = m;
        dwell_frames = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 32'(busy), 1);
        for (int v = 1; v <= nvis; v++) begin
            if (v > 1 && !fixed) begin
                m = rand_mask();
                d = 8'($urandom_range(0, 3));
            end
            enable_mask  = m;
            dwell_frames = d;
            nx = next_en(m, m_sel);
            visit(nx, nx != m_sel, eff(d), v == nvis);
            m_sel = nx;
        end
        expect_idle(m_sel);
    endtask

    initial begin
        logic [14:0] m;
        logic [5:0]  nx;
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        enable_mask = 15'd0;
        dwell_frames = 8'd0;
        frame_start = 1'b0;
        repeat (3) tick();
        check("rst_sel", 32'(sel), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_arm", 32'(capture_arm), 0);
        check("rst_switch", 32'(switch_pulse), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        m_sel = 6'd1;

        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("idle_stop_ignored", 32'(busy), 0);
        enable_mask = 15'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("zero_mask_start_busy", 32'(busy), 0);
        check("zero_mask_start_sel", 32'(sel), 1);

        run_scan(4, 1'b1, 15'h0005, 8'd2);
        run_scan(2, 1'b1, 15'h4000, 8'd1);
        run_scan(3, 1'b1, 15'h0F0F, 8'd0);
        run_scan(1, 1'b1, 15'h0842, 8'd3);

        // start and stop together: one select change, then idle
        m = rand_mask();
        enable_mask = m;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("ss_busy", 32'(busy), 1);
        nx = next_en(m, m_sel);
        tick();
        check("ss_sel", 32'(sel), 32'(nx));
        check("ss_switch", 32'(switch_pulse), 32'(nx != m_sel));
        check("ss_busy_after", 32'(busy), 0);
        m_sel = nx;
        for (int i = 0; i < 6; i++) begin
            frame_start = 1'($urandom_range(0, 1));
            tick();
            check("ss_no_arm", 32'(capture_arm), 0);
        end
        frame_start = 1'b0;

        // mask cleared before the next SEEK ends the scan with sel held
        m = rand_mask();
        enable_mask  = m;
        dwell_frames = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        enable_mask = m;
        nx = next_en(m, m_sel);
        visit(nx, nx != m_sel, 1, 1'b0);
        m_sel = nx;
        enable_mask = 15'd0;
        expect_idle(m_sel);

        for (int s = 0; s < 20; s++) begin
            run_scan($urandom_range(1, 4), 1'b0, 15'd0, 8'd0);
        end

        // asynchronous reset in the middle of a capture
        m = rand_mask();
        enable_mask  = m;
        dwell_frames = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        nx = next_en(m, m_sel);
        tick();
        check("pre_rst_sel", 32'(sel), 32'(nx));
        repeat (S) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("pre_rst_arm", 32'(capture_arm), 1);
        tick();
        #2 rst = 1'b1;
        #1;
        check("arst_sel", 32'(sel), 1);
        check("arst_busy", 32'(busy), 0);
        check("arst_frame_cnt", 32'(frame_cnt), 0);
        check("arst_state", 32'(dbg_state), 32'(IDLE));
        tick();
        rst = 1'b0;
        m_sel = 6'd1;
        for (int i = 0; i < 8; i++) begin
            frame_start = 1'($urandom_range(0, 1));
            stop        = 1'($urandom_range(0, 1));
            tick();
            check("post_rst_arm", 32'(capture_arm), 0);
            check("post_rst_switch", 32'(switch_pulse), 0);
            check("post_rst_busy", 32'(busy), 0);
        end
        frame_start = 1'b0;
        stop = 1'b0;
        run_scan(2, 1'b0, 15'd0, 8'd0);

        check("sel_range_violations", 32'(bad_range), 0);
        check("sel_change_vs_pulse", 32'(bad_sw), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
